// File: rtl/rv32_mem_pkg.sv
// Shared memory-port types: arbiter FSM states and RV32 load/store size codes.
// latency: n/a; backpressure: n/a.
package rv32_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        D_WAIT  = 2'd2
    } arb_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [2:0] FETCH_FUNCT3 = LW;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle of the memory port arbiter.
// latency: n/a; backpressure: requests are held until the matching valid pulse.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;

    logic              d_req;
    logic              d_we;
    logic [2:0]        d_funct3;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              d_stall;

    logic              mem_req;
    logic              mem_we;
    logic [2:0]        mem_funct3;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    // arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
               mem_ready, mem_rdata,
        output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_req, mem_we, mem_funct3, mem_addr, mem_wdata
    );

    // requesters plus memory
    modport master (
        output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
               mem_ready, mem_rdata,
        input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_req, mem_we, mem_funct3, mem_addr, mem_wdata
    );
endinterface

// File: rtl/arb_starve_counter.sv
// Counts data grants won while a fetch waits; starved flags the fetch's turn.
// latency: 1 cycle inc/clr to starved; backpressure: saturates at LIMIT.
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic starved
);
    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (clr) begin
            cnt <= 4'd0;
        end else if (inc && (cnt != 4'(LIMIT))) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign starved = (cnt == 4'(LIMIT));
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data requesters, data first with a starvation bound.
// latency: 2 cycles request to valid minimum; backpressure: stall held until the valid pulse.
module mem_port_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    mem_port_arbiter_if.slave bus
);
    arb_state_t state;
    logic if_pend, d_pend, idle_go, grant_if, grant_d, starved, cnt_inc, cnt_clr;

    // a requester's req in its own valid cycle is the completed one, not a new one
    assign if_pend  = bus.if_req && !bus.if_valid;
    assign d_pend   = bus.d_req  && !bus.d_valid;
    assign idle_go  = (state == IDLE) && enable;
    assign grant_d  = idle_go && d_pend && !(if_pend && starved);
    assign grant_if = idle_go && if_pend && !grant_d;

    assign cnt_inc = grant_d && bus.if_req;
    assign cnt_clr = grant_if || (grant_d && !bus.if_req);

    assign bus.if_stall = bus.if_req && !bus.if_valid;
    assign bus.d_stall  = bus.d_req  && !bus.d_valid;

    arb_starve_counter #(.LIMIT(STARVE_MAX)) u_starve (
        .clk     (clk),
        .rst     (rst),
        .inc     (cnt_inc),
        .clr     (cnt_clr),
        .starved (starved)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_funct3 <= 3'b000;
            bus.mem_addr   <= {ADDR_W{1'b0}};
            bus.mem_wdata  <= {DATA_W{1'b0}};
            bus.if_rdata   <= {DATA_W{1'b0}};
            bus.d_rdata    <= {DATA_W{1'b0}};
            bus.if_valid   <= 1'b0;
            bus.d_valid    <= 1'b0;
        end else begin
            bus.if_valid <= 1'b0;
            bus.d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        bus.mem_req    <= 1'b1;
                        bus.mem_we     <= bus.d_we;
                        bus.mem_funct3 <= bus.d_funct3;
                        bus.mem_addr   <= bus.d_addr;
                        bus.mem_wdata  <= bus.d_wdata;
                        state          <= D_WAIT;
                    end else if (grant_if) begin
                        bus.mem_req    <= 1'b1;
                        bus.mem_we     <= 1'b0;
                        bus.mem_funct3 <= FETCH_FUNCT3;
                        bus.mem_addr   <= bus.if_addr;
                        state          <= IF_WAIT;
                    end
                end
                IF_WAIT: begin
                    if (bus.mem_ready) begin
                        bus.mem_req  <= 1'b0;
                        bus.if_rdata <= bus.mem_rdata;
                        bus.if_valid <= 1'b1;
                        state        <= IDLE;
                    end
                end
                D_WAIT: begin
                    if (bus.mem_ready) begin
                        bus.mem_req <= 1'b0;
                        if (!bus.mem_we) begin
                            bus.d_rdata <= bus.mem_rdata;
                        end
                        bus.d_valid <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_mem_port_arbiter;
    import rv32_mem_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus)
    );

    int checks = 0;
    int failures = 0;

    // memory responder controls
    int          lat = 0;
    int          age = 0;
    logic        force_rdy = 1'b0;
    logic [31:0] rdata_next = 32'h0;
    byte         vlog[$];

    // reference model: who owns the port, the request it carries, and the returned data
    int          m_owner;   // 0 none, 1 fetch, 2 data
    logic        m_we;
    logic [2:0]  m_f3;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
    logic        m_if_valid, m_d_valid;
    int          m_data_wins;

    task automatic model_update();
        logic fetch_wants, data_wants, new_ifv, new_dv;
        if (rst) begin
            m_owner = 0; m_we = 0; m_f3 = 0; m_addr = 0; m_wdata = 0;
            m_if_rdata = 0; m_d_rdata = 0; m_if_valid = 0; m_d_valid = 0;
            m_data_wins = 0;
            return;
        end
        new_ifv = 0;
        new_dv  = 0;
        if (m_owner != 0) begin
            if (bus.mem_ready) begin
                if (m_owner == 1) begin
                    m_if_rdata = bus.mem_rdata;
                    new_ifv = 1;
                end else begin
                    if (!m_we) m_d_rdata = bus.mem_rdata;
                    new_dv = 1;
                end
                m_owner = 0;
            end
        end else if (enable) begin
            fetch_wants = bus.if_req && !m_if_valid;
            data_wants  = bus.d_req && !m_d_valid;
            if (data_wants && !(fetch_wants && m_data_wins == SMAX)) begin
                m_owner = 2; m_we = bus.d_we; m_f3 = bus.d_funct3;
                m_addr = bus.d_addr; m_wdata = bus.d_wdata;
                m_data_wins = bus.if_req ? ((m_data_wins < SMAX) ? m_data_wins + 1 : SMAX) : 0;
            end else if (fetch_wants) begin
                m_owner = 1; m_we = 0; m_f3 = 3'b010; m_addr = bus.if_addr;
                m_data_wins = 0;
            end
        end
        m_if_valid = new_ifv;
        m_d_valid  = new_dv;
    endtask

    task automatic step();
        int nage;
        bus.mem_ready = force_rdy || (bus.mem_req && (age >= lat));
        bus.mem_rdata = rdata_next;
        nage = (!rst && bus.mem_req && !bus.mem_ready) ? age + 1 : 0;
        model_update();
        @(posedge clk);
        @(negedge clk);
        age = nage;
        if (bus.if_valid) vlog.push_back("F");
        if (bus.d_valid)  vlog.push_back("D");
    endtask

    task automatic do_reset();
        rst = 1; bus.if_req = 0; bus.d_req = 0; force_rdy = 0; enable = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        step();
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
            failures++; $display("FAIL reset_req_we got=%b%b exp=00", bus.mem_req, bus.mem_we);
        end
        checks++;
        if (bus.if_valid !== 1'b0 || bus.d_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valids got=%b%b exp=00", bus.if_valid, bus.d_valid);
        end
        checks++;
        if ({bus.mem_funct3, bus.mem_addr, bus.mem_wdata} !== '0) begin
            failures++; $display("FAIL reset_mem_fields got=%h exp=0", {bus.mem_funct3, bus.mem_addr, bus.mem_wdata});
        end
        checks++;
        if ({bus.if_rdata, bus.d_rdata} !== '0) begin
            failures++; $display("FAIL reset_rdata got=%h exp=0", {bus.if_rdata, bus.d_rdata});
        end
        rst = 0;
    endtask

    task automatic test_fetch_only();
        do_reset();
        bus.if_req = 1; bus.if_addr = 32'h10; lat = 0; rdata_next = 32'h00500093;
        #1;
        checks++;
        if (bus.if_stall !== 1'b1) begin failures++; $display("FAIL fetch_stall_c0 got=%b exp=1", bus.if_stall); end
        step();
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_funct3, bus.mem_addr} !== {1'b1, 1'b0, FETCH_FUNCT3, 32'h10}) begin
            failures++; $display("FAIL fetch_grant_c1 got=%b %b %b %h exp=1 0 010 10",
                                 bus.mem_req, bus.mem_we, bus.mem_funct3, bus.mem_addr);
        end
        checks++;
        if (bus.if_stall !== 1'b1 || bus.if_valid !== 1'b0) begin
            failures++; $display("FAIL fetch_stall_c1 got=%b/%b exp=1/0", bus.if_stall, bus.if_valid);
        end
        step();
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h00500093) begin
            failures++; $display("FAIL fetch_valid_c2 got=%b %h exp=1 00500093", bus.if_valid, bus.if_rdata);
        end
        checks++;
        if (bus.if_stall !== 1'b0) begin failures++; $display("FAIL fetch_stall_c2 got=%b exp=0", bus.if_stall); end
        step();  // if_req still held in the valid cycle
        checks++;
        if (bus.mem_req !== 1'b0 || bus.if_valid !== 1'b0) begin
            failures++; $display("FAIL fetch_no_regrant got=%b/%b exp=0/0", bus.mem_req, bus.if_valid);
        end
        bus.if_req = 0;
        step();
        step();
    endtask

    task automatic test_store();
        logic [31:0] prev;
        int waits;
        int pulses;
        do_reset();
        prev = bus.d_rdata;
        bus.d_req = 1; bus.d_we = 1; bus.d_funct3 = SW; bus.d_addr = 32'h40;
        bus.d_wdata = 32'hDEADBEEF; lat = 3; rdata_next = 32'h12345678;
        step();
        waits = 0;
        while (!bus.d_valid && waits < 20) begin
            checks++;
            if ({bus.mem_req, bus.mem_we, bus.mem_funct3, bus.mem_addr, bus.mem_wdata} !==
                {1'b1, 1'b1, SW, 32'h40, 32'hDEADBEEF}) begin
                failures++; $display("FAIL store_hold wait=%0d got=%b %b %b %h %h exp=1 1 010 40 deadbeef",
                    waits, bus.mem_req, bus.mem_we, bus.mem_funct3, bus.mem_addr, bus.mem_wdata);
            end
            step();
            waits++;
        end
        checks++;
        if (waits != 4) begin failures++; $display("FAIL store_latency got=%0d exp=4", waits); end
        checks++;
        if (bus.d_rdata !== prev) begin failures++; $display("FAIL store_rdata got=%h exp=%h", bus.d_rdata, prev); end
        bus.d_req = 0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.d_valid) pulses++;
        end
        checks++;
        if (pulses != 0 || bus.mem_req !== 1'b0) begin
            failures++; $display("FAIL store_single_valid got=%0d extra mem_req=%b exp=0 0", pulses, bus.mem_req);
        end
    endtask

    task automatic test_back_to_back();
        int waits;
        do_reset();
        bus.if_req = 1; bus.if_addr = 32'h20; lat = 1; rdata_next = 32'h11111111;
        step();
        bus.d_req = 1; bus.d_we = 0; bus.d_funct3 = LW; bus.d_addr = 32'h80;
        waits = 0;
        while (!bus.if_valid && waits < 20) begin step(); waits++; end
        checks++;
        if (!bus.if_valid) begin failures++; $display("FAIL b2b_fetch_timeout got=0 exp=1"); end
        rdata_next = 32'hCAFEF00D;
        step();
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h80}) begin
            failures++; $display("FAIL b2b_data_grant got=%b %b %h exp=1 0 80", bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        bus.if_req = 0;
        waits = 0;
        while (!bus.d_valid && waits < 20) begin step(); waits++; end
        checks++;
        if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'hCAFEF00D) begin
            failures++; $display("FAIL b2b_load_data got=%b %h exp=1 cafef00d", bus.d_valid, bus.d_rdata);
        end
        bus.d_req = 0;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.d_req = 1; bus.d_we = 0; bus.d_funct3 = LW; bus.d_addr = 32'h44; lat = 100;
        rdata_next = 32'h55AA55AA;
        step();
        checks++;
        if (bus.mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_grant got=%b exp=1", bus.mem_req); end
        step();
        rst = 1; bus.d_req = 0;
        step();
        rst = 0;
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_funct3, bus.mem_addr, bus.d_valid, bus.d_rdata} !== '0) begin
            failures++; $display("FAIL rstmid_clear got=%b %h %b %h exp=0", bus.mem_req, bus.mem_addr, bus.d_valid, bus.d_rdata);
        end
        force_rdy = 1;
        step();
        force_rdy = 0;
        checks++;
        if (bus.d_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
            failures++; $display("FAIL rstmid_ready_ignored got=%b/%b exp=0/0", bus.d_valid, bus.mem_req);
        end
        step();
        checks++;
        if (bus.d_valid !== 1'b0 || bus.d_rdata !== 32'h0 || bus.mem_req !== 1'b0) begin
            failures++; $display("FAIL rstmid_idle got=%b %h %b exp=0 0 0", bus.d_valid, bus.d_rdata, bus.mem_req);
        end
        lat = 0;
    endtask

    task automatic test_enable();
        do_reset();
        enable = 0; lat = 0;
        bus.if_req = 1; bus.if_addr = 32'h30;
        bus.d_req = 1; bus.d_we = 1; bus.d_funct3 = SB; bus.d_addr = 32'h90; bus.d_wdata = 32'hA5;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL enable_block cyc=%0d got=%b exp=0", i, bus.mem_req); end
        end
        enable = 1;
        step();
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b1, 32'h90}) begin
            failures++; $display("FAIL enable_data_first got=%b %b %h exp=1 1 90", bus.mem_req, bus.mem_we, bus.mem_addr);
        end
    endtask

    task automatic test_starvation();
        string exp_s;
        int n;
        exp_s = "DDDDFDDDDF";
        do_reset();
        lat = 0;
        bus.if_req = 1; bus.if_addr = 32'h100;
        bus.d_req = 1; bus.d_we = 0; bus.d_funct3 = LW; bus.d_addr = 32'h200;
        vlog.delete();
        n = 0;
        // enable drops in each data valid cycle so the next grant sees both requesters pending
        while (vlog.size() < 10 && n < 200) begin
            step();
            enable = !bus.d_valid;
            checks++;
            if (bus.if_valid && bus.d_valid) begin failures++; $display("FAIL starve_dual_valid got=11 exp=not both"); end
            n++;
        end
        checks++;
        if (vlog.size() < 10) begin
            failures++; $display("FAIL starve_timeout got=%0d exp=10", vlog.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (vlog[i] != exp_s[i]) begin
                    failures++; $display("FAIL starve_seq idx=%0d got=%c exp=%c", i, vlog[i], exp_s[i]);
                end
            end
        end
        enable = 1; bus.if_req = 0; bus.d_req = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (!bus.if_req || m_if_valid) begin
                bus.if_req = ($urandom % 4) != 0;
                bus.if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!bus.d_req || m_d_valid) begin
                bus.d_req = ($urandom % 3) != 0;
                bus.d_we = $urandom % 2;
                bus.d_funct3 = $urandom % 8;
                bus.d_addr = $urandom;
                bus.d_wdata = $urandom;
            end
            enable = ($urandom % 10) != 0;
            rst = ($urandom % 150) == 0;
            if (!bus.mem_req) lat = $urandom % 4;
            rdata_next = $urandom;
            #1;
            checks++;
            if (bus.if_stall !== (bus.if_req && !m_if_valid) || bus.d_stall !== (bus.d_req && !m_d_valid)) begin
                failures++; $display("FAIL rnd_stall cyc=%0d got=%b%b exp=%b%b", c, bus.if_stall, bus.d_stall,
                                     bus.if_req && !m_if_valid, bus.d_req && !m_d_valid);
            end
            step();
            checks++;
            if (bus.mem_req !== (m_owner != 0)) begin
                failures++; $display("FAIL rnd_mem_req cyc=%0d got=%b exp=%b", c, bus.mem_req, m_owner != 0);
            end
            checks++;
            if ({bus.mem_we, bus.mem_funct3, bus.mem_addr} !== {m_we, m_f3, m_addr}) begin
                failures++; $display("FAIL rnd_mem_fields cyc=%0d got=%b %b %h exp=%b %b %h",
                                     c, bus.mem_we, bus.mem_funct3, bus.mem_addr, m_we, m_f3, m_addr);
            end
            checks++;
            if (m_we && bus.mem_wdata !== m_wdata) begin
                failures++; $display("FAIL rnd_mem_wdata cyc=%0d got=%h exp=%h", c, bus.mem_wdata, m_wdata);
            end
            checks++;
            if ({bus.if_valid, bus.d_valid} !== {m_if_valid, m_d_valid}) begin
                failures++; $display("FAIL rnd_valids cyc=%0d got=%b%b exp=%b%b", c, bus.if_valid, bus.d_valid, m_if_valid, m_d_valid);
            end
            checks++;
            if ({bus.if_rdata, bus.d_rdata} !== {m_if_rdata, m_d_rdata}) begin
                failures++; $display("FAIL rnd_rdata cyc=%0d got=%h %h exp=%h %h", c, bus.if_rdata, bus.d_rdata, m_if_rdata, m_d_rdata);
            end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1; enable = 1;
        bus.if_req = 0; bus.if_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_funct3 = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bus.mem_ready = 0; bus.mem_rdata = 0;
        @(negedge clk);
        test_reset();
        test_fetch_only();
        test_store();
        test_back_to_back();
        test_reset_mid();
        test_enable();
        test_starvation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
